// File: rtl/arb2_pkg.sv
// Shared definitions for the two-source round-robin select stage:
// grant encodings, output-register state encoding and grant-counter width.
package arb2_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int CNT_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/MUX2x1.sv
// Plain 2:1 operand multiplexer: y = sel ? b : a.
module MUX2x1 #(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 sel,
  output logic [DATAWIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/arb2_sel_stage.sv
// Two-source round-robin arbiter feeding a single-entry output register.
// A word is accepted from the granted source whenever the output register is
// empty or being drained in the same cycle, giving one word per cycle.
// Optional build macro ARB2_GRANT_STATS_EN adds saturating per-source
// acceptance counters (a_count / b_count).
module arb2_sel_stage
  import arb2_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 a_valid,
  input  logic [DATAWIDTH-1:0] a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [DATAWIDTH-1:0] b_data,
  output logic                 b_ready,
  output logic                 out_valid,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_src,
  input  logic                 out_ready,
  output logic                 sel
`ifdef ARB2_GRANT_STATS_EN
  ,
  output logic [CNT_W-1:0]     a_count,
  output logic [CNT_W-1:0]     b_count
`endif
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_last_grant;
  logic [DATAWIDTH-1:0]   r_out_data;
  logic                   r_out_src;

  logic                   w_can_accept;
  logic                   w_any_valid;
  logic                   w_grant;
  logic                   w_accept;
  logic [DATAWIDTH-1:0]   w_mux_data;

  assign w_can_accept = (r_state == EMPTY) || out_ready;
  assign w_any_valid  = a_valid || b_valid;
  // Reset masks acceptance so readys stay low while Rst is high.
  assign w_accept     = w_can_accept && w_any_valid && !Rst;

  // Grant: a lone requester wins; a tie goes to whoever lost last time;
  // with no requester the select just parks on the previous grant.
  always_comb begin
    w_grant = r_last_grant;
    if (a_valid && !b_valid)      w_grant = SEL_A;
    else if (b_valid && !a_valid) w_grant = SEL_B;
    else if (a_valid && b_valid)  w_grant = ~r_last_grant;
  end

  assign a_ready   = w_accept && (w_grant == SEL_A);
  assign b_ready   = w_accept && (w_grant == SEL_B);
  assign sel       = w_grant;
  assign out_valid = (r_state == FULL);
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

  MUX2x1 #(
    .DATAWIDTH (DATAWIDTH)
  ) u_mux (
    .a   (a_data),
    .b   (b_data),
    .sel (w_grant),
    .y   (w_mux_data)
  );

  // Output-register occupancy state.
  always_ff @(posedge Clk) begin
    if (Rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Fill on accept; empty only when drained with nothing new arriving.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_accept) w_state_nxt = FULL;
      FULL:    if (out_ready && !w_accept) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Capture the granted operand and remember who won; hold otherwise.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_out_data   <= '0;
      r_out_src    <= SEL_A;
      r_last_grant <= SEL_B;
    end else if (w_accept) begin
      r_out_data   <= w_mux_data;
      r_out_src    <= w_grant;
      r_last_grant <= w_grant;
    end
  end

`ifdef ARB2_GRANT_STATS_EN
  logic [CNT_W-1:0] r_a_count;
  logic [CNT_W-1:0] r_b_count;

  // Per-source acceptance counters, saturating at all-ones.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_a_count <= '0;
      r_b_count <= '0;
    end else begin
      if (a_ready) r_a_count <= sat_inc(r_a_count);
      if (b_ready) r_b_count <= sat_inc(r_b_count);
    end
  end

  assign a_count = r_a_count;
  assign b_count = r_b_count;
`endif

endmodule

// File: tb/tb_arb2_sel_stage.sv
// Scoreboard bench for arb2_sel_stage (DATAWIDTH=8): a reference model pushes
// expected words on acceptance, a monitor pops them as the DUT presents them.
module tb_arb2_sel_stage;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_ready, b_ready, out_valid, out_src, sel;
  logic [7:0] out_data;
`ifdef ARB2_GRANT_STATS_EN
  logic [15:0] a_count, b_count;
`endif

  arb2_sel_stage #(.DATAWIDTH(8)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .sel       (sel)
`ifdef ARB2_GRANT_STATS_EN
    ,
    .a_count   (a_count),
    .b_count   (b_count)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] d;
    logic       s;
  } word_t;

  word_t q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one-word buffer, round-robin on ties, first tie to A.
  bit m_full = 1'b0;
  bit m_last = 1'b1;

  always @(negedge Clk) begin
    bit any, can, g, ea, eb;
    if (Rst) begin
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      m_full = 1'b0;
      m_last = 1'b1;
      q.delete();
    end else begin
      chk("out_valid", out_valid, m_full);
      any = a_valid || b_valid;
      can = !m_full || out_ready;
      g   = (a_valid && b_valid) ? !m_last : b_valid;
      ea  = can && any && !g;
      eb  = can && any && g;
      chk("a_ready", a_ready, ea);
      chk("b_ready", b_ready, eb);
      chk("sel", sel, any ? g : m_last);
      if (ea || eb) begin
        q.push_back('{d: (g ? b_data : a_data), s: g});
        m_last = g;
        m_full = 1'b1;
      end else if (m_full && out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: every presented word must match the oldest expected word.
  always @(negedge Clk) begin
    if (!Rst && out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got %0h expected none (t=%0t)", out_data, $time);
      end else begin
        chk("out_data", out_data, q[0].d);
        chk("out_src", out_src, q[0].s);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic cyc(input bit av, input logic [7:0] ad, input bit bv,
                     input logic [7:0] bd, input bit ordy, input bit rst);
    @(posedge Clk);
    #1;
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
    out_ready = ordy; Rst = rst;
    @(negedge Clk);
  endtask

  initial begin
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h11; exp_seq[3] = 8'h22;

    // Reset state
    cyc(0, 8'h00, 0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 8'h00, 0, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 8'h00);
    chk("reset_out_src", out_src, 0);

    // Single A word, one-cycle latency
    cyc(1, 8'h3C, 0, 8'h00, 1, 0);
    chk("single_a_ready", a_ready, 1);
    cyc(0, 8'h00, 0, 8'h00, 1, 0);
    chk("single_out_valid", out_valid, 1);
    chk("single_out_data", out_data, 8'h3C);
    chk("single_out_src", out_src, 0);

    // Persistent tie alternates starting with A, full throughput
    cyc(0, 8'h00, 0, 8'h00, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'h11, 1, 8'h22, 1, 0);
      if (i > 0) begin
        chk("alt_out_valid", out_valid, 1);
        chk("alt_out_data", out_data, exp_seq[i-1]);
      end
    end

    // Stall holds the word and blocks both sources
    cyc(0, 8'h00, 0, 8'h00, 0, 1);
    cyc(1, 8'h55, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8'h66, 1, 8'h77, 0, 0);
      chk("stall_a_ready", a_ready, 0);
      chk("stall_b_ready", b_ready, 0);
      chk("stall_out_data", out_data, 8'h55);
    end
    cyc(1, 8'h66, 1, 8'h77, 1, 0);
    chk("unstall_b_ready", b_ready, 1);
    cyc(0, 8'h00, 0, 8'h00, 1, 0);
    chk("unstall_out_data", out_data, 8'h77);
    chk("unstall_out_src", out_src, 1);

    // Drain with no new word empties the stage, data holds
    cyc(0, 8'h00, 0, 8'h00, 1, 0);
    chk("drain_out_valid", out_valid, 0);
    chk("drain_out_data", out_data, 8'h77);

    // Reset while stalled discards the word; next tie goes to A
    cyc(1, 8'h99, 0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 8'h00, 0, 1);
    cyc(1, 8'h12, 1, 8'h34, 0, 0);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_out_data", out_data, 8'h00);
    chk("rst_mid_tie_a", a_ready, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)),
          8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
    end

`ifdef ARB2_GRANT_STATS_EN
    // Counter saturation
    cyc(0, 8'h00, 0, 8'h00, 1, 1);
    for (int i = 0; i < 65537; i++) cyc(1, 8'($urandom), 0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 0);
    chk("a_count_sat", a_count, 16'hFFFF);
    chk("b_count_idle", b_count, 16'h0000);
`endif

    cyc(0, 8'h00, 0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
